// File: rtl/stream_framer.sv
// stream_framer: counts stencil beats over a 4-D image, tags tlast, and buffers output in a 2-entry skid FIFO
module stream_framer #(
  parameter int IMG_EXTENT_0 = 256,
  parameter int IMG_EXTENT_1 = 256,
  parameter int IMG_EXTENT_2 = 1,
  parameter int IMG_EXTENT_3 = 1,
  parameter int ST_EXTENT_0 = 1,
  parameter int ST_EXTENT_1 = 1,
  parameter int ST_EXTENT_2 = 1,
  parameter int ST_EXTENT_3 = 1,
  parameter int DATA_SIZE = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start_in,
  input  logic [ST_EXTENT_3-1:0][ST_EXTENT_2-1:0][ST_EXTENT_1-1:0][ST_EXTENT_0-1:0][DATA_SIZE-1:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic [ST_EXTENT_3-1:0][ST_EXTENT_2-1:0][ST_EXTENT_1-1:0][ST_EXTENT_0-1:0][DATA_SIZE-1:0] tdata,
  output logic tvalid,
  output logic tlast,
  input  logic tready,
  output logic busy,
  output logic done_out
);
  localparam int W = DATA_SIZE * ST_EXTENT_0 * ST_EXTENT_1 * ST_EXTENT_2 * ST_EXTENT_3;
  localparam int IMAX01 = IMG_EXTENT_0 > IMG_EXTENT_1 ? IMG_EXTENT_0 : IMG_EXTENT_1;
  localparam int IMAX23 = IMG_EXTENT_2 > IMG_EXTENT_3 ? IMG_EXTENT_2 : IMG_EXTENT_3;
  localparam int IW = $clog2(IMAX01 > IMAX23 ? IMAX01 : IMAX23) + 1;
  localparam logic [3:0][IW-1:0] LAST = {IW'(IMG_EXTENT_3 - ST_EXTENT_3), IW'(IMG_EXTENT_2 - ST_EXTENT_2),
                                         IW'(IMG_EXTENT_1 - ST_EXTENT_1), IW'(IMG_EXTENT_0 - ST_EXTENT_0)};
  localparam logic [3:0][IW-1:0] STEP = {IW'(ST_EXTENT_3), IW'(ST_EXTENT_2), IW'(ST_EXTENT_1), IW'(ST_EXTENT_0)};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;
  logic [1:0] occ_q, occ_d;
  logic [3:0][IW-1:0] idx_q, idx_d;
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic done_q, done_d;
  logic push, pop, last_beat, carry;

  assign in_ready = (state_q == RUN) && !occ_q[1];
  assign tvalid = occ_q != 2'd0;
  assign tlast = head_last_q & tvalid;
  assign tdata = head_q;
  assign busy = state_q != IDLE;
  assign done_out = done_q;
  assign push = in_valid & in_ready;
  assign pop = tvalid & tready;
  assign last_beat = idx_q == LAST;

  // Frame control: arm on start, stop accepting after the last beat, finish when it leaves downstream
  always_comb begin
    state_d = state_q;
    done_d = 1'b0;
    if (state_q == IDLE && start_in) state_d = RUN;
    else if (state_q == RUN && push && last_beat) state_d = DRAIN;
    else if (state_q == DRAIN && pop && tlast) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end

  // Beat position counters: idx_0 fastest, each wraps and carries into the next dimension
  always_comb begin
    idx_d = idx_q;
    carry = push;
    for (int n = 0; n < 4; n++) begin
      if (carry) begin
        idx_d[n] = (idx_q[n] == LAST[n]) ? '0 : idx_q[n] + STEP[n];
        carry = idx_q[n] == LAST[n];
      end
    end
    if (state_q == IDLE && start_in) idx_d = '0;
  end

  // Skid FIFO: head feeds the outputs; an incoming beat lands in head when the FIFO is empty after any pop
  always_comb begin
    head_d = head_q;
    head_last_d = head_last_q;
    tail_d = tail_q;
    tail_last_d = tail_last_q;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    if (pop) begin
      head_d = tail_q;
      head_last_d = tail_last_q;
    end
    if (push && (occ_q - {1'b0, pop}) == 2'd0) begin
      head_d = in_data;
      head_last_d = last_beat;
    end else if (push) begin
      tail_d = in_data;
      tail_last_d = last_beat;
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      occ_q <= '0;
      idx_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      head_last_q <= 1'b0;
      tail_last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q <= occ_d;
      idx_q <= idx_d;
      head_q <= head_d;
      tail_q <= tail_d;
      head_last_q <= head_last_d;
      tail_last_q <= tail_last_d;
      done_q <= done_d;
    end
  end
endmodule
